wb_commit: RTL and testbench
============================

# wb_commit

Architectural-state write-back sink for the five-stage pipeline. Consumes the registered write-back bundle (GPR write, HI/LO write, LLbit write) and commits it to the 32×32 general-purpose register file, the HI/LO pair and the LLbit. Also serves the decode-stage GPR read ports and the execute/memory-stage HI/LO and LLbit reads, with same-cycle write-through bypass so that readers never see stale state.

## Interface
Parameters:
- none; widths come from the shared macro set (`RegBus` = 32, `RegAddrBus` = 5).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-high (asserted when equal to `RstEnable`, 1'b1); the name is kept for codebase consistency.
- `wb_wreg` in 1: GPR write enable.
- `wb_wd` in 5: GPR write address.
- `wb_wdata` in 32: GPR write data.
- `wb_whilo` in 1: HI/LO write enable; writes both HI and LO together.
- `wb_hi` in 32, `wb_lo` in 32: HI/LO write data.
- `wb_LLbit_we` in 1, `wb_LLbit_value` in 1: LLbit write.
- `flush` in 1: exception flush from pipeline control; clears LLbit.
- `re1` in 1, `raddr1` in 5, `rdata1` out 32: GPR read port 1, combinational.
- `re2` in 1, `raddr2` in 5, `rdata2` out 32: GPR read port 2, combinational.
- `hi_o` out 32, `lo_o` out 32: current HI/LO, bypassed.
- `LLbit_o` out 1: current LLbit, bypassed.

## Operation
- GPR write: on a clock edge with no reset, `wb_wreg`=1 and `wb_wd`≠0, `regs[wb_wd]` ← `wb_wdata`. Writes to r0 are silently discarded.
- GPR read on port n. Rules are applied in order:
  - During reset: 0.
  - `raddrn`=0: 0.
  - `ren`=0: 0.
  - `ren`=1, `wb_wreg`=1 and `raddrn`=`wb_wd`: `wb_wdata` (write-through bypass).
  - Otherwise: `regs[raddrn]`.
- Both read ports are independent. Both may hit the bypass in the same cycle.
- HI/LO: when `wb_whilo`=1, HI ← `wb_hi` and LO ← `wb_lo`.
  - `hi_o`/`lo_o` show `wb_hi`/`wb_lo` when `wb_whilo`=1; otherwise they show the stored values.
  - During reset they read 0.
- LLbit update priority: reset > `flush` > `wb_LLbit_we`.
  - `flush`=1 clears LLbit to 0, even when `wb_LLbit_we`=1 in the same cycle.
- `LLbit_o` bypass:
  - 0 when `flush`=1.
  - Otherwise `wb_LLbit_value` when `wb_LLbit_we`=1.
  - Otherwise the stored LLbit.
- Stall handling: none. An upstream bubble arrives as deasserted enables and is a no-op.

## Timing
- Reset, sampled on a clock edge:
  - HI, LO and LLbit are cleared to 0.
  - All 32 GPRs are cleared to 0, so reads after reset are deterministic.
  - While `rst_n` is high, every output reads 0.
- Write latency is one edge: state updated at edge k is visible from the stored path in cycle k+1. It is visible in cycle k through the bypass.
- Read paths are purely combinational; there are no read-side registers.
- Reset asserted mid-stream: any write presented in that cycle is dropped.
- Simultaneous GPR write and HI/LO write in one cycle are both committed; they are independent.

## Structure
- `RegBus`, `RegAddrBus`, `RstEnable`, `ZeroWord`, `WriteEnable` and `ReadEnable` come from the shared macro include. No new shared constants are needed.
- One sub-module is natural: `gpr_file`, the 32×32 array with its write port and two bypassed read ports.
- HI/LO and LLbit stay as flat logic in the top module.

## Test plan
- Reset check: hold `rst_n`=1 for 2 cycles, then release and read all 32 addresses on both ports → every read returns 0; `hi_o`=`lo_o`=0; `LLbit_o`=0.
- r0 protection: write `wd`=0, data 0xDEADBEEF, then read `raddr1`=0 → 0. Write `wd`=5, data 0x12345678 → the next cycle `rdata2` at `raddr2`=5 = 0x12345678.
- Bypass: in one cycle present write `wd`=7 with 0xA5A5A5A5 and read `raddr1`=`raddr2`=7 → both ports return 0xA5A5A5A5 in the same cycle. With `re1`=0 → `rdata1`=0.
- HI/LO: `wb_whilo`=1 with `hi`=0x1, `lo`=0x2 → `hi_o`/`lo_o` read 1/2 that cycle and in the following cycles. With `wb_whilo`=0 and new data presented → the outputs stay 1/2.
- LLbit priority: `wb_LLbit_we`=1 and value 1 → `LLbit_o`=1, and it stays set. Then `flush`=1 together with `we`=1, value 1 → `LLbit_o`=0 that cycle and the next.
- Reset mid-write: assert `rst_n` together with write `wd`=3, data 0xFF → after reset, reg 3 reads 0.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared constants for the write-back commit block.
// Provides the bus widths and the enable/reset encodings used by the
// GPR file and the HI/LO/LLbit logic.
package wb_commit_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;

  localparam logic              RstEnable   = 1'b1;
  localparam logic              WriteEnable = 1'b1;
  localparam logic              ReadEnable  = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord    = '0;

endpackage

// File: rtl/wb_commit_gpr_file.sv
// 32x32 general-purpose register file with one write port and two
// combinational read ports that bypass the write port in the same cycle.
// Ports:
//   clk, rst_n          clock, synchronous active-high reset (clears all regs)
//   we, waddr, wdata    write port (writes to r0 are discarded)
//   re1, raddr1, rdata1 read port 1
//   re2, raddr2, rdata2 read port 2
// Read result priority: reset -> addr 0 -> read disabled -> bypass -> stored.
module wb_commit_gpr_file
  import wb_commit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [RegAddrBus-1:0] waddr,
  input  logic [RegBus-1:0]     wdata,
  input  logic                  re1,
  input  logic [RegAddrBus-1:0] raddr1,
  output logic [RegBus-1:0]     rdata1,
  input  logic                  re2,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic [RegBus-1:0]     rdata2
);

  logic [RegBus-1:0] regs [0:RegNum-1];

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      for (int i = 0; i < RegNum; i++) begin
        regs[i] <= ZeroWord;
      end
    end else if ((we == WriteEnable) && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = ZeroWord;
    if (rst_n == RstEnable) begin
      rdata1 = ZeroWord;
    end else if (raddr1 == '0) begin
      rdata1 = ZeroWord;
    end else if (re1 != ReadEnable) begin
      rdata1 = ZeroWord;
    end else if ((we == WriteEnable) && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = ZeroWord;
    if (rst_n == RstEnable) begin
      rdata2 = ZeroWord;
    end else if (raddr2 == '0) begin
      rdata2 = ZeroWord;
    end else if (re2 != ReadEnable) begin
      rdata2 = ZeroWord;
    end else if ((we == WriteEnable) && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Architectural-state write-back sink. Commits the registered write-back
// bundle to the GPR file, the HI/LO pair and the LLbit, and serves the
// readers with same-cycle write-through bypass.
// Ports:
//   clk, rst_n                     clock, synchronous active-high reset
//   wb_wreg, wb_wd, wb_wdata       GPR write
//   wb_whilo, wb_hi, wb_lo         HI/LO write (both halves together)
//   wb_LLbit_we, wb_LLbit_value    LLbit write
//   flush                          exception flush, clears LLbit
//   re1/raddr1/rdata1, re2/raddr2/rdata2   GPR read ports (combinational)
//   hi_o, lo_o, LLbit_o            bypassed HI/LO/LLbit
// There is no handshake: every input is a per-cycle command, a deasserted
// enable is a bubble and commits nothing. All outputs read 0 during reset.
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_wreg,
  input  logic [RegAddrBus-1:0] wb_wd,
  input  logic [RegBus-1:0]     wb_wdata,
  input  logic                  wb_whilo,
  input  logic [RegBus-1:0]     wb_hi,
  input  logic [RegBus-1:0]     wb_lo,
  input  logic                  wb_LLbit_we,
  input  logic                  wb_LLbit_value,
  input  logic                  flush,
  input  logic                  re1,
  input  logic [RegAddrBus-1:0] raddr1,
  output logic [RegBus-1:0]     rdata1,
  input  logic                  re2,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic [RegBus-1:0]     rdata2,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o,
  output logic                  LLbit_o
);

  logic [RegBus-1:0] hi;
  logic [RegBus-1:0] lo;
  logic              llbit;

  wb_commit_gpr_file u_gpr_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_wreg),
    .waddr  (wb_wd),
    .wdata  (wb_wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      hi <= ZeroWord;
      lo <= ZeroWord;
    end else if (wb_whilo == WriteEnable) begin
      hi <= wb_hi;
      lo <= wb_lo;
    end
  end

  // Flush wins over a same-cycle LL write: an exception must kill any
  // reservation being established by the faulting instruction stream.
  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      llbit <= 1'b0;
    end else if (flush) begin
      llbit <= 1'b0;
    end else if (wb_LLbit_we == WriteEnable) begin
      llbit <= wb_LLbit_value;
    end
  end

  always_comb begin
    hi_o = ZeroWord;
    lo_o = ZeroWord;
    if (rst_n == RstEnable) begin
      hi_o = ZeroWord;
      lo_o = ZeroWord;
    end else if (wb_whilo == WriteEnable) begin
      hi_o = wb_hi;
      lo_o = wb_lo;
    end else begin
      hi_o = hi;
      lo_o = lo;
    end
  end

  always_comb begin
    LLbit_o = 1'b0;
    if (rst_n == RstEnable) begin
      LLbit_o = 1'b0;
    end else if (flush) begin
      LLbit_o = 1'b0;
    end else if (wb_LLbit_we == WriteEnable) begin
      LLbit_o = wb_LLbit_value;
    end else begin
      LLbit_o = llbit;
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
module tb_wb_commit;

  localparam int W = 32;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          wb_wreg;
  logic [4:0]    wb_wd;
  logic [W-1:0]  wb_wdata;
  logic          wb_whilo;
  logic [W-1:0]  wb_hi;
  logic [W-1:0]  wb_lo;
  logic          wb_LLbit_we;
  logic          wb_LLbit_value;
  logic          flush;
  logic          re1;
  logic [4:0]    raddr1;
  logic [W-1:0]  rdata1;
  logic          re2;
  logic [4:0]    raddr2;
  logic [W-1:0]  rdata2;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;
  logic          LLbit_o;

  wb_commit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_wreg        (wb_wreg),
    .wb_wd          (wb_wd),
    .wb_wdata       (wb_wdata),
    .wb_whilo       (wb_whilo),
    .wb_hi          (wb_hi),
    .wb_lo          (wb_lo),
    .wb_LLbit_we    (wb_LLbit_we),
    .wb_LLbit_value (wb_LLbit_value),
    .flush          (flush),
    .re1            (re1),
    .raddr1         (raddr1),
    .rdata1         (rdata1),
    .re2            (re2),
    .raddr2         (raddr2),
    .rdata2         (rdata2),
    .hi_o           (hi_o),
    .lo_o           (lo_o),
    .LLbit_o        (LLbit_o)
  );

  // ---------------- scoreboard ----------------
  // Output selectors for queued expectations.
  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_HI  = 2;
  localparam int SEL_LO  = 3;
  localparam int SEL_LL  = 4;

  logic [W-1:0] exp_q[$];
  int           sel_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  function automatic string sel_name(input int s);
    case (s)
      SEL_RD1: return "rdata1";
      SEL_RD2: return "rdata2";
      SEL_HI:  return "hi_o";
      SEL_LO:  return "lo_o";
      default: return "LLbit_o";
    endcase
  endfunction

  // Monitor: outputs are combinational, so every cycle's expectations are
  // drained on the falling edge, half a period after inputs settle.
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    int           s;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      s     = sel_q.pop_front();
      case (s)
        SEL_RD1: act_v = rdata1;
        SEL_RD2: act_v = rdata2;
        SEL_HI:  act_v = hi_o;
        SEL_LO:  act_v = lo_o;
        default: act_v = {{(W-1){1'b0}}, LLbit_o};
      endcase
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h",
                 sel_name(s), $time, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    wb_wreg        = 1'b0;
    wb_wd          = '0;
    wb_wdata       = '0;
    wb_whilo       = 1'b0;
    wb_hi          = '0;
    wb_lo          = '0;
    wb_LLbit_we    = 1'b0;
    wb_LLbit_value = 1'b0;
    flush          = 1'b0;
    re1            = 1'b0;
    raddr1         = '0;
    re2            = 1'b0;
    raddr2         = '0;
  endtask

  task automatic expect_out(input int s, input logic [W-1:0] v);
    sel_q.push_back(s);
    exp_q.push_back(v);
  endtask

  task automatic gpr_write(input logic [4:0] a, input logic [W-1:0] d);
    wb_wreg  = 1'b1;
    wb_wd    = a;
    wb_wdata = d;
  endtask

  task automatic read_ports(input logic e1, input logic [4:0] a1,
                            input logic e2, input logic [4:0] a2);
    re1    = e1;
    raddr1 = a1;
    re2    = e2;
    raddr2 = a2;
  endtask

  // Let the monitor check this cycle, then commit on the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #1;

    // Reset held for 2 cycles with every write enable asserted: all
    // outputs must still read 0 and none of the writes may land.
    for (int c = 0; c < 2; c++) begin
      gpr_write(5'd4, 32'h0000_0001);
      wb_whilo = 1'b1; wb_hi = 32'hAAAA_AAAA; wb_lo = 32'hBBBB_BBBB;
      wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
      read_ports(1'b1, 5'd4, 1'b1, 5'd4);
      expect_out(SEL_RD1, 32'h0); expect_out(SEL_RD2, 32'h0);
      expect_out(SEL_HI, 32'h0);  expect_out(SEL_LO, 32'h0);
      expect_out(SEL_LL, 32'h0);
      step();
    end

    // Post-reset sweep of every address on both ports.
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      read_ports(1'b1, 5'(i), 1'b1, 5'(31 - i));
      expect_out(SEL_RD1, 32'h0); expect_out(SEL_RD2, 32'h0);
      expect_out(SEL_HI, 32'h0);  expect_out(SEL_LO, 32'h0);
      expect_out(SEL_LL, 32'h0);
      step();
    end

    // r0 protection: the write is dropped and the bypass does not fire.
    idle_inputs();
    gpr_write(5'd0, 32'hDEAD_BEEF);
    read_ports(1'b1, 5'd0, 1'b1, 5'd0);
    expect_out(SEL_RD1, 32'h0); expect_out(SEL_RD2, 32'h0);
    step();
    idle_inputs();
    read_ports(1'b1, 5'd0, 1'b0, 5'd0);
    expect_out(SEL_RD1, 32'h0);
    step();

    // Write r5, bypass in the write cycle, stored value the next cycle.
    idle_inputs();
    gpr_write(5'd5, 32'h1234_5678);
    read_ports(1'b0, 5'd0, 1'b1, 5'd5);
    expect_out(SEL_RD2, 32'h1234_5678);
    step();
    idle_inputs();
    read_ports(1'b0, 5'd5, 1'b1, 5'd5);
    expect_out(SEL_RD1, 32'h0);
    expect_out(SEL_RD2, 32'h1234_5678);
    step();

    // Dual bypass on r7.
    idle_inputs();
    gpr_write(5'd7, 32'hA5A5_A5A5);
    read_ports(1'b1, 5'd7, 1'b1, 5'd7);
    expect_out(SEL_RD1, 32'hA5A5_A5A5); expect_out(SEL_RD2, 32'hA5A5_A5A5);
    step();
    // Bypass suppressed on a disabled port while the other port takes it.
    idle_inputs();
    gpr_write(5'd7, 32'h1111_1111);
    read_ports(1'b0, 5'd7, 1'b1, 5'd7);
    expect_out(SEL_RD1, 32'h0); expect_out(SEL_RD2, 32'h1111_1111);
    step();
    // One port bypassing (r9), the other reading stored (r5).
    idle_inputs();
    gpr_write(5'd9, 32'h0000_0099);
    read_ports(1'b1, 5'd5, 1'b1, 5'd9);
    expect_out(SEL_RD1, 32'h1234_5678); expect_out(SEL_RD2, 32'h0000_0099);
    step();
    idle_inputs();
    read_ports(1'b1, 5'd7, 1'b1, 5'd9);
    expect_out(SEL_RD1, 32'h1111_1111); expect_out(SEL_RD2, 32'h0000_0099);
    step();

    // HI/LO bypass, hold, and ignored data when not enabled.
    idle_inputs();
    wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
    expect_out(SEL_HI, 32'h1); expect_out(SEL_LO, 32'h2);
    step();
    for (int c = 0; c < 2; c++) begin
      idle_inputs();
      wb_hi = 32'h3; wb_lo = 32'h4;
      expect_out(SEL_HI, 32'h1); expect_out(SEL_LO, 32'h2);
      step();
    end

    // GPR and HI/LO written together are independent.
    idle_inputs();
    gpr_write(5'd10, 32'h0000_000A);
    wb_whilo = 1'b1; wb_hi = 32'h5; wb_lo = 32'h6;
    step();
    idle_inputs();
    read_ports(1'b1, 5'd10, 1'b0, 5'd10);
    expect_out(SEL_RD1, 32'h0000_000A); expect_out(SEL_RD2, 32'h0);
    expect_out(SEL_HI, 32'h5); expect_out(SEL_LO, 32'h6);
    step();

    // LLbit set, hold, flush priority over a same-cycle write, stay clear.
    idle_inputs();
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    expect_out(SEL_LL, 32'h1);
    step();
    idle_inputs();
    expect_out(SEL_LL, 32'h1);
    step();
    idle_inputs();
    flush = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    expect_out(SEL_LL, 32'h0);
    step();
    idle_inputs();
    expect_out(SEL_LL, 32'h0);
    step();
    // Set again, then an explicit write of 0 clears it through the bypass.
    idle_inputs();
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    step();
    idle_inputs();
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b0;
    expect_out(SEL_LL, 32'h0);
    step();
    idle_inputs();
    expect_out(SEL_LL, 32'h0);
    step();
    // Leave LLbit set so the next reset has something to clear.
    idle_inputs();
    wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    step();

    // Reset mid-write: the r3 write is dropped and all state is cleared.
    idle_inputs();
    rst_n = 1'b1;
    gpr_write(5'd3, 32'h0000_00FF);
    read_ports(1'b1, 5'd3, 1'b1, 5'd5);
    expect_out(SEL_RD1, 32'h0); expect_out(SEL_RD2, 32'h0);
    step();
    rst_n = 1'b0;
    idle_inputs();
    read_ports(1'b1, 5'd3, 1'b1, 5'd5);
    expect_out(SEL_RD1, 32'h0); expect_out(SEL_RD2, 32'h0);
    expect_out(SEL_HI, 32'h0);  expect_out(SEL_LO, 32'h0);
    expect_out(SEL_LL, 32'h0);
    step();

    // ---------------- final report ----------------
    idle_inputs();
    step();
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is short, so this only trips on a hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
